input_feed_ctrl: RTL and testbench

//  Sequences the systolic-array input buffer. On start it issues tile-sized bursts
//  of the buffer read strobe (row 0 read; lower rows self-skew via o_valid chain),

---
 rtl/input_feed_ctrl.sv | 165 ++++++++++++++++
 tb/tb_input_feed_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_feed_ctrl.sv
// Sequences systolic-array input-buffer reads: per tile, accumulator handshake, row burst, skew drain.
// Latency: start to first read strobe is 2 cycles when acc_ready is already high; all outputs are state decodes (Moore).
// Backpressure: acc_ready gates only the start of each tile; once streaming, the burst and drain run to completion.
//
// Ports:
//   clk, rst              clock (posedge) and asynchronous active-high reset
//   start, abort          job request (IDLE only) and synchronous abort (wins over start)
//   cfg_rows, cfg_tiles   rows per tile and tiles per job, latched on an accepted start
//   acc_ready             accumulator can take a new tile
//   read                  read strobe to input_buffer (row 0; lower rows self-skew)
//   busy                  controller is not IDLE
//   tile_idx              0-based index of the current tile
//   tile_done, done       one-cycle pulses: last drain cycle of a tile / job complete
module input_feed_ctrl #(
  parameter int SYS_ROWS = 4,
  parameter int SYS_COLS = 4,
  parameter int ROWS_W   = 16,
  parameter int TILES_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ROWS_W-1:0]  cfg_rows,
  input  logic [TILES_W-1:0] cfg_tiles,
  input  logic               acc_ready,
  output logic               read,
  output logic               busy,
  output logic [TILES_W-1:0] tile_idx,
  output logic               tile_done,
  output logic               done
);

  // Cycles needed for the last row's data to skew out through the whole array.
  localparam int DRAIN_CYC = SYS_ROWS + SYS_COLS;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [ROWS_W-1:0]  rows_q, rows_nxt;
  logic [TILES_W-1:0] tiles_q, tiles_nxt;
  logic [ROWS_W-1:0]  row_cnt, row_cnt_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;
  logic [TILES_W-1:0] tile_idx_q, tile_idx_nxt;

  logic row_last;
  logic drain_last;
  logic tile_last;

  // Compare-before-increment: counters stop at limit-1, so the maximum
  // configurable rows/tiles never wrap a counter. rows_q and tiles_q are
  // non-zero whenever these terms are used (zero jobs go straight to DONE).
  assign row_last   = (row_cnt == rows_q - ROWS_W'(1));
  assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_CYC - 1));
  assign tile_last  = (tile_idx_q == tiles_q - TILES_W'(1));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rows_q     <= '0;
      tiles_q    <= '0;
      row_cnt    <= '0;
      drain_cnt  <= '0;
      tile_idx_q <= '0;
    end else begin
      state      <= state_nxt;
      rows_q     <= rows_nxt;
      tiles_q    <= tiles_nxt;
      row_cnt    <= row_cnt_nxt;
      drain_cnt  <= drain_cnt_nxt;
      tile_idx_q <= tile_idx_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt     = state;
    rows_nxt      = rows_q;
    tiles_nxt     = tiles_q;
    row_cnt_nxt   = row_cnt;
    drain_cnt_nxt = drain_cnt;
    tile_idx_nxt  = tile_idx_q;

    case (state)
      S_IDLE: begin
        if (start) begin
          rows_nxt      = cfg_rows;
          tiles_nxt     = cfg_tiles;
          tile_idx_nxt  = '0;
          row_cnt_nxt   = '0;
          drain_cnt_nxt = '0;
          // An empty job still reports completion, without touching the buffer.
          if ((cfg_rows == '0) || (cfg_tiles == '0)) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT_RDY;
          end
        end
      end

      S_WAIT_RDY: begin
        if (acc_ready) begin
          row_cnt_nxt = '0;
          state_nxt   = S_STREAM;
        end
      end

      S_STREAM: begin
        if (row_last) begin
          drain_cnt_nxt = '0;
          state_nxt     = S_DRAIN;
        end else begin
          row_cnt_nxt = row_cnt + ROWS_W'(1);
        end
      end

      S_DRAIN: begin
        if (drain_last) begin
          if (tile_last) begin
            state_nxt = S_DONE;
          end else begin
            tile_idx_nxt = tile_idx_q + TILES_W'(1);
            state_nxt    = S_WAIT_RDY;
          end
        end else begin
          drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
        end
      end

      S_DONE: begin
        // tile_idx deliberately keeps the last tile number until the next start.
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a start seen in the same cycle.
    if (abort) begin
      state_nxt     = S_IDLE;
      row_cnt_nxt   = '0;
      drain_cnt_nxt = '0;
      tile_idx_nxt  = '0;
    end
  end

  // Moore outputs: pure decodes of registered state, so an async reset
  // clears them immediately.
  assign read      = (state == S_STREAM);
  assign busy      = (state != S_IDLE);
  assign tile_done = (state == S_DRAIN) && drain_last;
  assign done      = (state == S_DONE);
  assign tile_idx  = tile_idx_q;

endmodule

// File: tb/tb_input_feed_ctrl.sv
// Directed bench for input_feed_ctrl (4x4 array, drain of 8 cycles).
// Cycle c0 is the cycle start is driven; the controller sees it on the edge ending c0.
module tb_input_feed_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] cfg_rows;
  logic [7:0]  cfg_tiles;
  logic        acc_ready;
  logic        read;
  logic        busy;
  logic [7:0]  tile_idx;
  logic        tile_done;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  input_feed_ctrl #(
    .SYS_ROWS(4),
    .SYS_COLS(4),
    .ROWS_W  (16),
    .TILES_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cfg_rows (cfg_rows),
    .cfg_tiles(cfg_tiles),
    .acc_ready(acc_ready),
    .read     (read),
    .busy     (busy),
    .tile_idx (tile_idx),
    .tile_done(tile_done),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; acc_ready = 1'b0;
    cfg_rows = '0; cfg_tiles = '0;
    #3;
    n_cmp++;
    if ({read, busy, tile_idx, tile_done, done} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 000", {read, busy, tile_idx, tile_done, done});
    end
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({read, busy, tile_idx, tile_done, done} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_release_idle: got %h expected 000", {read, busy, tile_idx, tile_done, done});
    end
  endtask

  // rows=3, tiles=2, acc_ready always high.
  task automatic test_basic();
    logic [26:0] rd_v, td_v, dn_v, bs_v;
    logic [7:0]  ti5, ti14, ti26;
    rd_v = '0; td_v = '0; dn_v = '0; bs_v = '0;
    ti5 = '0; ti14 = '0; ti26 = '0;
    for (int c = 0; c < 27; c++) begin
      if (c == 0) begin
        cfg_rows = 16'd3; cfg_tiles = 8'd2; acc_ready = 1'b1; start = 1'b1;
      end
      if (c == 1) start = 1'b0;
      rd_v[c] = read; td_v[c] = tile_done; dn_v[c] = done; bs_v[c] = busy;
      if (c == 5)  ti5  = tile_idx;
      if (c == 14) ti14 = tile_idx;
      if (c == 26) ti26 = tile_idx;
      step();
    end
    n_cmp++;
    if (rd_v !== 27'h001C01C) begin n_err++; $display("FAIL basic_read: got %h expected %h", rd_v, 27'h001C01C); end
    n_cmp++;
    if (td_v !== 27'h1001000) begin n_err++; $display("FAIL basic_tile_done: got %h expected %h", td_v, 27'h1001000); end
    n_cmp++;
    if (dn_v !== 27'h2000000) begin n_err++; $display("FAIL basic_done: got %h expected %h", dn_v, 27'h2000000); end
    n_cmp++;
    if (bs_v !== 27'h3FFFFFE) begin n_err++; $display("FAIL basic_busy: got %h expected %h", bs_v, 27'h3FFFFFE); end
    n_cmp++;
    if (ti5 !== 8'd0) begin n_err++; $display("FAIL basic_tile_idx_t0: got %0d expected 0", ti5); end
    n_cmp++;
    if (ti14 !== 8'd1) begin n_err++; $display("FAIL basic_tile_idx_t1: got %0d expected 1", ti14); end
    n_cmp++;
    if (ti26 !== 8'd1) begin n_err++; $display("FAIL basic_tile_idx_hold: got %0d expected 1", ti26); end
  endtask

  // rows=2, tiles=1, acc_ready low for c0..c9 and high from c10.
  task automatic test_acc_wait();
    logic [23:0] rd_v, td_v, dn_v, bs_v;
    rd_v = '0; td_v = '0; dn_v = '0; bs_v = '0;
    for (int c = 0; c < 24; c++) begin
      if (c == 0) begin
        cfg_rows = 16'd2; cfg_tiles = 8'd1; acc_ready = 1'b0; start = 1'b1;
      end
      if (c == 1)  start = 1'b0;
      if (c == 10) acc_ready = 1'b1;
      rd_v[c] = read; td_v[c] = tile_done; dn_v[c] = done; bs_v[c] = busy;
      step();
    end
    n_cmp++;
    if (rd_v !== 24'h001800) begin n_err++; $display("FAIL wait_read: got %h expected %h", rd_v, 24'h001800); end
    n_cmp++;
    if (td_v !== 24'h100000) begin n_err++; $display("FAIL wait_tile_done: got %h expected %h", td_v, 24'h100000); end
    n_cmp++;
    if (dn_v !== 24'h200000) begin n_err++; $display("FAIL wait_done: got %h expected %h", dn_v, 24'h200000); end
    n_cmp++;
    if (bs_v !== 24'h3FFFFE) begin n_err++; $display("FAIL wait_busy: got %h expected %h", bs_v, 24'h3FFFFE); end
  endtask

  // Second start with new cfg during STREAM must be ignored.
  task automatic test_start_busy();
    logic [19:0] rd_v, td_v, dn_v;
    rd_v = '0; td_v = '0; dn_v = '0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) begin
        cfg_rows = 16'd3; cfg_tiles = 8'd1; acc_ready = 1'b1; start = 1'b1;
      end
      if (c == 1) start = 1'b0;
      if (c == 3) begin
        start = 1'b1; cfg_rows = 16'd9; cfg_tiles = 8'd5;
      end
      if (c == 4) start = 1'b0;
      rd_v[c] = read; td_v[c] = tile_done; dn_v[c] = done;
      step();
    end
    n_cmp++;
    if (rd_v !== 20'h0001C) begin n_err++; $display("FAIL busy_start_read: got %h expected %h", rd_v, 20'h0001C); end
    n_cmp++;
    if (td_v !== 20'h01000) begin n_err++; $display("FAIL busy_start_tile_done: got %h expected %h", td_v, 20'h01000); end
    n_cmp++;
    if (dn_v !== 20'h02000) begin n_err++; $display("FAIL busy_start_done: got %h expected %h", dn_v, 20'h02000); end
  endtask

  // rows=5, tiles=3, abort in 3rd STREAM cycle of tile 1 (c18); then a full job.
  task automatic test_abort();
    logic [30:0] rd_v, td_v, dn_v, bs_v;
    logic [7:0]  ti18, ti19;
    int          n_rd, n_td, done_cyc;
    logic [7:0]  ti_done;
    rd_v = '0; td_v = '0; dn_v = '0; bs_v = '0; ti18 = '0; ti19 = '1;
    for (int c = 0; c < 31; c++) begin
      if (c == 0) begin
        cfg_rows = 16'd5; cfg_tiles = 8'd3; acc_ready = 1'b1; start = 1'b1;
      end
      if (c == 1)  start = 1'b0;
      if (c == 18) abort = 1'b1;
      if (c == 19) abort = 1'b0;
      rd_v[c] = read; td_v[c] = tile_done; dn_v[c] = done; bs_v[c] = busy;
      if (c == 18) ti18 = tile_idx;
      if (c == 19) ti19 = tile_idx;
      step();
    end
    n_cmp++;
    if (rd_v !== 31'h0007007C) begin n_err++; $display("FAIL abort_read: got %h expected %h", rd_v, 31'h0007007C); end
    n_cmp++;
    if (bs_v !== 31'h0007FFFE) begin n_err++; $display("FAIL abort_busy: got %h expected %h", bs_v, 31'h0007FFFE); end
    n_cmp++;
    if (td_v !== 31'h00004000) begin n_err++; $display("FAIL abort_tile_done: got %h expected %h", td_v, 31'h00004000); end
    n_cmp++;
    if (dn_v !== 31'h0) begin n_err++; $display("FAIL abort_no_done: got %h expected 0", dn_v); end
    n_cmp++;
    if (ti18 !== 8'd1) begin n_err++; $display("FAIL abort_tile_idx_before: got %0d expected 1", ti18); end
    n_cmp++;
    if (ti19 !== 8'd0) begin n_err++; $display("FAIL abort_tile_idx_after: got %0d expected 0", ti19); end

    // Full job afterwards: each tile = 1 wait + 5 reads + 8 drain = 14 cycles.
    n_rd = 0; n_td = 0; done_cyc = -1; ti_done = '0;
    for (int c = 0; c < 46; c++) begin
      if (c == 0) start = 1'b1;
      if (c == 1) start = 1'b0;
      if (read) n_rd++;
      if (tile_done) n_td++;
      if (done) begin
        done_cyc = c;
        ti_done  = tile_idx;
      end
      step();
    end
    n_cmp++;
    if (n_rd != 15) begin n_err++; $display("FAIL rerun_read_count: got %0d expected 15", n_rd); end
    n_cmp++;
    if (n_td != 3) begin n_err++; $display("FAIL rerun_tile_done_count: got %0d expected 3", n_td); end
    n_cmp++;
    if (done_cyc != 43) begin n_err++; $display("FAIL rerun_done_cycle: got %0d expected 43", done_cyc); end
    n_cmp++;
    if (ti_done !== 8'd2) begin n_err++; $display("FAIL rerun_tile_idx_last: got %0d expected 2", ti_done); end

    // abort and start together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abort_start_same_cycle: busy got %b expected 0", busy); end
    step();
    n_cmp++;
    if (read !== 1'b0) begin n_err++; $display("FAIL abort_start_no_read: got %b expected 0", read); end
  endtask

  // rows=4, tiles=2; async reset mid-DRAIN of tile 1 (c22), then a rows=1 job.
  task automatic test_async_reset();
    logic        bs21;
    logic [7:0]  ti21;
    logic        td_seen;
    logic [13:0] rd_v, dn_v;
    bs21 = 1'b0; ti21 = '0; td_seen = 1'b0; rd_v = '0; dn_v = '0;
    for (int c = 0; c < 22; c++) begin
      if (c == 0) begin
        cfg_rows = 16'd4; cfg_tiles = 8'd2; acc_ready = 1'b1; start = 1'b1;
      end
      if (c == 1) start = 1'b0;
      if (c == 21) begin
        bs21 = busy;
        ti21 = tile_idx;
      end
      step();
    end
    n_cmp++;
    if ({bs21, ti21} !== 9'h101) begin n_err++; $display("FAIL rst_pre_state: got %h expected 101", {bs21, ti21}); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({read, busy, tile_idx, tile_done, done} !== 12'h000) begin
      n_err++;
      $display("FAIL rst_async_clear: got %h expected 000", {read, busy, tile_idx, tile_done, done});
    end
    for (int c = 0; c < 8; c++) begin
      if (tile_done) td_seen = 1'b1;
      step();
    end
    #2 rst = 1'b0;
    n_cmp++;
    if (td_seen !== 1'b0) begin n_err++; $display("FAIL rst_no_tile_done: got %b expected 0", td_seen); end
    step();
    for (int c = 0; c < 14; c++) begin
      if (c == 0) begin
        cfg_rows = 16'd1; cfg_tiles = 8'd1; start = 1'b1;
      end
      if (c == 1) start = 1'b0;
      rd_v[c] = read; dn_v[c] = done;
      step();
    end
    n_cmp++;
    if (rd_v !== 14'h0004) begin n_err++; $display("FAIL rst_rerun_read: got %h expected 0004", rd_v); end
    n_cmp++;
    if (dn_v !== 14'h0800) begin n_err++; $display("FAIL rst_rerun_done: got %h expected 0800", dn_v); end
  endtask

  // Empty jobs: no reads, done in the cycle after the start edge (IDLE -> DONE -> IDLE).
  task automatic test_zero_cfg();
    logic [4:0] rd_v, dn_v, bs_v;
    for (int k = 0; k < 2; k++) begin
      rd_v = '0; dn_v = '0; bs_v = '0;
      for (int c = 0; c < 5; c++) begin
        if (c == 0) begin
          cfg_rows  = (k == 0) ? 16'd0 : 16'd4;
          cfg_tiles = (k == 0) ? 8'd3  : 8'd0;
          acc_ready = 1'b1; start = 1'b1;
        end
        if (c == 1) start = 1'b0;
        rd_v[c] = read; dn_v[c] = done; bs_v[c] = busy;
        step();
      end
      n_cmp++;
      if (rd_v !== 5'h00) begin n_err++; $display("FAIL zero_cfg%0d_read: got %h expected 00", k, rd_v); end
      n_cmp++;
      if (dn_v !== 5'h02) begin n_err++; $display("FAIL zero_cfg%0d_done: got %h expected 02", k, dn_v); end
      n_cmp++;
      if (bs_v !== 5'h02) begin n_err++; $display("FAIL zero_cfg%0d_busy: got %h expected 02", k, bs_v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_acc_wait();
    test_start_busy();
    test_abort();
    test_async_reset();
    test_zero_cfg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
